// File: rtl/ccff_chain_loader_pkg.sv
// ccff_chain_loader_pkg: shared state encoding and byte width for the chain loader
package ccff_chain_loader_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams a bitstream into a ccff chain MSB-first and returns the old contents as readback bytes
module ccff_chain_loader
  import ccff_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W = 13
) (
  input  logic       prog_clk,
  input  logic       prog_reset_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       ccff_head,
  output logic       ccff_clk_en,
  input  logic       ccff_tail,
  output logic       rb_valid,
  input  logic       rb_ready,
  output logic [7:0] rb_data,
  output logic       busy,
  output logic       done
);
  state_t r_state, w_nxt;
  logic [7:0] r_shreg, r_rbreg;
  logic [CNT_W-1:0] r_remain;
  logic [3:0] r_nbits, r_blen, w_nbits_ld;
  logic r_in_ready, r_clk_en, r_head, r_rb_valid, r_busy, r_done;
  // a byte carries 8 chain bits except the final partial one
  assign w_nbits_ld = (r_remain >= CNT_W'(BYTE_W)) ? 4'(BYTE_W) : r_remain[3:0];
  // next-state decode; every output below is registered from this
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_nxt = start ? ST_LOAD : ST_IDLE;
      ST_LOAD:  w_nxt = in_valid ? ST_SHIFT : ST_LOAD;
      ST_SHIFT: w_nxt = (r_nbits == 4'd1) ? ST_DRAIN : ST_SHIFT;
      ST_DRAIN: w_nxt = rb_ready ? ((r_remain == '0) ? ST_DONE : ST_LOAD) : ST_DRAIN;
      default:  w_nxt = ST_IDLE;
    endcase
  end
  // FSM, datapath and registered outputs; async reset kills the chain clock at once
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_state    <= ST_IDLE;
      r_shreg    <= '0;
      r_rbreg    <= '0;
      r_remain   <= '0;
      r_nbits    <= '0;
      r_blen     <= '0;
      r_in_ready <= 1'b0;
      r_clk_en   <= 1'b0;
      r_head     <= 1'b0;
      r_rb_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_in_ready <= w_nxt == ST_LOAD;
      r_clk_en   <= w_nxt == ST_SHIFT;
      r_rb_valid <= w_nxt == ST_DRAIN;
      r_busy     <= w_nxt != ST_IDLE;
      r_done     <= w_nxt == ST_DONE;
      r_head     <= (w_nxt == ST_SHIFT) && ((r_state == ST_LOAD) ? in_data[7] : r_shreg[6]);
      if (r_state == ST_IDLE && start) r_remain <= CNT_W'(CHAIN_LEN);
      if (r_state == ST_LOAD && in_valid) begin
        r_shreg <= in_data;
        r_rbreg <= '0;
        r_nbits <= w_nbits_ld;
        r_blen  <= w_nbits_ld;
      end
      if (r_state == ST_SHIFT) begin
        r_shreg  <= {r_shreg[6:0], 1'b0};
        r_rbreg  <= {r_rbreg[6:0], ccff_tail};
        r_remain <= r_remain - 1'b1;
        r_nbits  <= r_nbits - 1'b1;
      end
    end
  end
  assign in_ready    = r_in_ready;
  assign ccff_clk_en = r_clk_en;
  assign ccff_head   = r_head;
  assign rb_valid    = r_rb_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign rb_data     = r_rbreg << (4'(BYTE_W) - r_blen);
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed checks of the chain loader at CHAIN_LEN 32, 12 and 1
module tb_ccff_chain_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_v [3];
  logic ival [3];
  logic [7:0] idat [3];
  logic irdy [3];
  logic head [3];
  logic en [3];
  logic tail [3];
  logic rbv [3];
  logic rbr [3];
  logic [7:0] rbd [3];
  logic bsy [3];
  logic dne [3];
  logic [31:0] chain [3];
  logic [31:0] pre_val;
  logic pre_en [3];
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] hs, rbw;
  int ens, cdone, ndone, nin, nrb, sten;

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(32)) u32 (.prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[0]),
    .in_valid(ival[0]), .in_ready(irdy[0]), .in_data(idat[0]), .ccff_head(head[0]), .ccff_clk_en(en[0]),
    .ccff_tail(tail[0]), .rb_valid(rbv[0]), .rb_ready(rbr[0]), .rb_data(rbd[0]), .busy(bsy[0]), .done(dne[0]));
  ccff_chain_loader #(.CHAIN_LEN(12)) u12 (.prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[1]),
    .in_valid(ival[1]), .in_ready(irdy[1]), .in_data(idat[1]), .ccff_head(head[1]), .ccff_clk_en(en[1]),
    .ccff_tail(tail[1]), .rb_valid(rbv[1]), .rb_ready(rbr[1]), .rb_data(rbd[1]), .busy(bsy[1]), .done(dne[1]));
  ccff_chain_loader #(.CHAIN_LEN(1)) u1 (.prog_clk(clk), .prog_reset_n(rst_n), .start(start_v[2]),
    .in_valid(ival[2]), .in_ready(irdy[2]), .in_data(idat[2]), .ccff_head(head[2]), .ccff_clk_en(en[2]),
    .ccff_tail(tail[2]), .rb_valid(rbv[2]), .rb_ready(rbr[2]), .rb_data(rbd[2]), .busy(bsy[2]), .done(dne[2]));

  // chain model: head enters bit 0, tail is bit CHAIN_LEN-1
  assign tail[0] = chain[0][31];
  assign tail[1] = chain[1][11];
  assign tail[2] = chain[2][0];
  always @(posedge clk)
    for (int j = 0; j < 3; j++)
      if (pre_en[j]) chain[j] <= pre_val;
      else if (en[j]) chain[j] <= {chain[j][30:0], head[j]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input int k, input logic [31:0] v);
    @(negedge clk);
    pre_val = v;
    pre_en[k] = 1'b1;
    @(negedge clk);
    pre_en[k] = 1'b0;
  endtask

  // one full load on instance k; cycle 1 is the cycle after start is sampled
  task automatic run(input int k, input logic [31:0] dw, input int nb, input int vs0, input int rs0, input bit rep,
                     output logic [31:0] o_hs, output logic [31:0] o_rb, output int o_ens, output int o_cdone,
                     output int o_ndone, output int o_nin, output int o_nrb, output int o_sten);
    int vs, rs, cyc;
    vs = vs0; rs = rs0;
    o_hs = '0; o_rb = '0; o_ens = 0; o_cdone = -1; o_ndone = 0; o_nin = 0; o_nrb = 0; o_sten = 0;
    @(negedge clk);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    cyc = 1;
    while (cyc < 300 && !(o_cdone > 0 && cyc > o_cdone + 3)) begin
      start_v[k] = rep && cyc == 5;
      if (dne[k]) begin
        o_ndone++;
        if (o_cdone < 0) o_cdone = cyc;
      end
      if (en[k]) begin
        o_ens++;
        o_hs = {o_hs[30:0], head[k]};
      end
      ival[k] = 1'b0;
      if (irdy[k]) begin
        if (vs > 0) begin
          vs--;
          if (en[k]) o_sten++;
        end else begin
          ival[k] = 1'b1;
          idat[k] = (o_nin < nb) ? dw[31 - 8*o_nin -: 8] : 8'h00;
          o_nin++;
        end
      end
      rbr[k] = 1'b0;
      if (rbv[k]) begin
        if (rs > 0) begin
          rs--;
          if (en[k]) o_sten++;
        end else begin
          rbr[k] = 1'b1;
          o_rb = {o_rb[23:0], rbd[k]};
          o_nrb++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start_v[k] = 1'b0;
    ival[k] = 1'b0;
    rbr[k] = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < 3; j++) begin
      start_v[j] = 0; ival[j] = 0; idat[j] = 0; rbr[j] = 0; pre_en[j] = 0;
    end
    pre_val = '0;
    #12;
    for (int j = 0; j < 3; j++)
      check($sformatf("reset_outs%0d", j), {22'd0, irdy[j], en[j], head[j], rbv[j], bsy[j], dne[j], rbd[j][3:0]} | {24'd0, rbd[j]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // full 32-bit load
    preload(0, 32'hDEADBEEF);
    run(0, 32'hA53CFF01, 4, 0, 0, 0, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("l32_head", hs, 32'hA53CFF01);
    check("l32_rb", rbw, 32'hDEADBEEF);
    check("l32_done_cyc", cdone, 41);
    check("l32_ens", ens, 32);
    check("l32_ndone", ndone, 1);
    check("l32_hs_counts", {nin[15:0], nrb[15:0]}, {16'd4, 16'd4});
    check("l32_chain", chain[0], 32'hA53CFF01);
    check("l32_idle", bsy[0], 0);

    // partial final byte
    preload(1, 32'h000005A3);
    run(1, 32'hF0AB0000, 2, 0, 0, 0, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("l12_head", hs, 32'h00000F0A);
    check("l12_rb", rbw, 32'h00005A30);
    check("l12_ens", ens, 12);
    check("l12_done_cyc", cdone, 17);
    check("l12_hs_counts", {nin[15:0], nrb[15:0]}, {16'd2, 16'd2});
    check("l12_chain", chain[1][11:0], 32'h00000F0A);

    // stalls on both handshakes
    preload(0, 32'h13579BDF);
    run(0, 32'h12345678, 4, 5, 3, 0, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("stall_head", hs, 32'h12345678);
    check("stall_rb", rbw, 32'h13579BDF);
    check("stall_done_cyc", cdone, 49);
    check("stall_ens", ens, 32);
    check("stall_clk_en", sten, 0);

    // start re-pulsed during SHIFT
    preload(0, 32'h12345678);
    run(0, 32'h0FF055AA, 4, 0, 0, 1, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("rep_head", hs, 32'h0FF055AA);
    check("rep_rb", rbw, 32'h12345678);
    check("rep_ndone", ndone, 1);
    check("rep_done_cyc", cdone, 41);

    // reset during the third SHIFT cycle
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    ival[0] = 1'b1;
    idat[0] = 8'hFF;
    @(negedge clk);
    ival[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_en", en[0], 1);
    rst_n = 1'b0;
    #1;
    check("rst_en_drop", en[0], 0);
    check("rst_busy_drop", bsy[0], 0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (dne[0]) ndone++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (dne[0] || bsy[0]) ndone++;
    end
    check("rst_no_done", ndone, 0);
    preload(0, 32'hCAFEF00D);
    run(0, 32'h01234567, 4, 0, 0, 0, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("post_rst_head", hs, 32'h01234567);
    check("post_rst_rb", rbw, 32'hCAFEF00D);
    check("post_rst_done_cyc", cdone, 41);
    check("post_rst_ens", ens, 32);

    // single-bit chain
    preload(2, 32'h00000001);
    run(2, 32'h80000000, 1, 0, 0, 0, hs, rbw, ens, cdone, ndone, nin, nrb, sten);
    check("l1_head", hs, 32'h00000001);
    check("l1_ens", ens, 1);
    check("l1_rb", rbw, 32'h00000080);
    check("l1_done_cyc", cdone, 4);
    check("l1_ndone", ndone, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 32, gives the number of configuration flip-flops in the downstream ccff chain (one connection block); legal range 1..4096.
REQ-002 Parameter CNT_W, default 13, gives the width of the remaining-bit counter; it SHALL be at least clog2(CHAIN_LEN+1).
REQ-003 prog_clk  in  1  single clock: one clock; reset is asynchronous and active-low.
REQ-004 prog_reset_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle request to begin a full chain load.
REQ-006 in_valid / in_ready / in_data  in/out/in  1/1/8  bitstream byte stream; MSB is shifted first.
REQ-007 ccff_head  out  1  serial data into the chain head.
REQ-008 ccff_clk_en  out  1  enable for the external prog_clk gate; the chain advances one bit per cycle while it is high.
REQ-009 ccff_tail  in  1  serial data returned from the chain tail.
REQ-010 rb_valid / rb_ready / rb_data  out/in/out  1/1/8  readback byte of the previous chain contents.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at the end of a complete load.

Function
REQ-013 The FSM SHALL have the states IDLE, LOAD, SHIFT, DRAIN and DONE.
REQ-014 IDLE: start=1 loads remain=CHAIN_LEN and moves to LOAD; start in any other state is ignored.
REQ-015 LOAD: in_ready=1; on in_valid&in_ready, in_data is latched into shreg, nbits=min(8,remain), and the FSM moves to SHIFT; in_ready=0 in all other states.
REQ-016 SHIFT: ccff_clk_en=1 and ccff_head=shreg[7]; each cycle shreg shifts left by one, ccff_tail shifts into the LSB of rbreg, remain decrements and nbits decrements; when nbits reaches 0 the FSM moves to DRAIN.
REQ-017 Outside SHIFT, ccff_clk_en=0 and ccff_head=0; both SHALL be driven only from registers, with no combinational path from any input.
REQ-018 DRAIN: rb_valid=1 and rb_data=rbreg left-aligned, with unused LSBs zero for a partial final byte; the FSM holds until rb_ready.
REQ-019 On the DRAIN handshake the FSM moves to DONE if remain=0, otherwise to LOAD.
REQ-020 DONE: done=1 for one cycle, then the FSM returns to IDLE.
REQ-021 A partial final byte (CHAIN_LEN mod 8 ≠ 0) shifts only its top CHAIN_LEN mod 8 bits; the remaining input bits are discarded.
REQ-022 Stalls: in_valid low in LOAD, or rb_ready low in DRAIN, SHALL hold all state, with ccff_clk_en=0 so the chain does not move.
REQ-023 Latency: with in_valid and rb_ready held high, one byte takes 10 cycles (1 LOAD, 8 SHIFT, 1 DRAIN); done asserts 4*10+1=41 cycles after start is sampled when CHAIN_LEN=32.
REQ-024 Exactly CHAIN_LEN ccff_clk_en cycles SHALL occur per load, and exactly ceil(CHAIN_LEN/8) input and readback handshakes.

Reset
REQ-025 On prog_reset_n low, asynchronously: state=IDLE; shreg, rbreg, remain and nbits=0; all outputs low.
REQ-026 Reset asserted mid-load SHALL drop ccff_clk_en in the same cycle; the partial chain contents are left undefined, and no done pulse is issued.
REQ-027 Reset release SHALL be synchronous to prog_clk (external synchroniser); the FSM leaves IDLE only on a subsequent start.

Structure
REQ-028 The shared package holds the state enum and the constant BYTE_W=8.
REQ-029 No sub-module is needed; the counters and shift registers are inline.

Verification
REQ-030 CHAIN_LEN=32, bytes A5,3C,FF,01, always ready/valid, chain model preloaded with 0xDEADBEEF -> head stream equals 0xA53CFF01 MSB-first; rb bytes DE,AD,BE,EF; done at cycle 41; ccff_clk_en count = 32.
REQ-031 CHAIN_LEN=12, bytes F0,AB -> second byte shifts only bits 1010; rb_data for the second byte has its 4 LSBs zero; done after 2 byte handshakes.
REQ-032 in_valid withheld 5 cycles in LOAD and rb_ready withheld 3 cycles in DRAIN -> ccff_clk_en stays 0 during the stalls; data and counts are unchanged; done is delayed by 8 cycles.
REQ-033 start re-pulsed during SHIFT -> ignored; the load completes normally with a single done.
REQ-034 prog_reset_n asserted during the 3rd SHIFT cycle -> ccff_clk_en and busy drop immediately, no done; a fresh start then performs a full 32-bit load correctly.
REQ-035 CHAIN_LEN=1, byte 80 -> one ccff_clk_en cycle with ccff_head=1; rb_data = {tail,7'b0}; done pulses.
